// File: rtl/clock_edge_monitor.sv
// Brings a slow asynchronous clock/strobe into the clock_in domain as edge pulses,
// measures its period and high time, and tracks lock/timeout of the incoming edges.
module clock_edge_monitor #(
  parameter int unsigned          CNT_WIDTH = 28,
  parameter logic [CNT_WIDTH-1:0] TIMEOUT   = CNT_WIDTH'(100_000_000)
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  input  logic                 slow_in,
  output logic                 slow_sync,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 locked,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_LOCKED,
    ST_TIMEOUT
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 s1;
  logic                 s2;
  logic                 s3;
  logic                 rise_det_c;
  logic                 fall_det_c;
  logic                 period_load_c;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] hcnt;

  // s1/s2 resolve metastability; s3 is the previous synchronized value for edge detection
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= slow_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign slow_sync  = s2;
  assign rise_det_c = s2 & ~s3;
  assign fall_det_c = ~s2 & s3;

  // Period and high-phase counters, both restarting at 1 on a rising edge and saturating
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      hcnt <= '0;
    end else begin
      if (rise_det_c) begin
        cnt <= CNT_ONE;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end

      if (rise_det_c) begin
        hcnt <= CNT_ONE;
      end else if (s2 && (hcnt != CNT_MAX)) begin
        hcnt <= hcnt + CNT_ONE;
      end
    end
  end

  // Edge pulses and the high-time capture at the end of each high phase
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      high_time  <= '0;
    end else begin
      rise_pulse <= rise_det_c;
      fall_pulse <= fall_det_c;
      if (fall_det_c) begin
        high_time <= hcnt;
      end
    end
  end

  // State register with registered decodes and the period capture
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      locked       <= 1'b0;
      timeout      <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      locked       <= (state_d == ST_LOCKED);
      timeout      <= (state_d == ST_TIMEOUT);
      period_valid <= period_load_c;
      if (period_load_c) begin
        period <= cnt;
      end
    end
  end

  // A period is only trusted when the previous rise was seen while not timed out
  always_comb begin
    state_d       = state_q;
    period_load_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_det_c) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (rise_det_c) begin
          state_d       = ST_LOCKED;
          period_load_c = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (rise_det_c) period_load_c = 1'b1;
      end
      ST_TIMEOUT: begin
        if (rise_det_c) state_d = ST_ARMED;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!rise_det_c && (cnt >= TIMEOUT)) begin
      state_d = ST_TIMEOUT;
    end
  end

endmodule
